fir4_tdm_sched: RTL

FIR4_TDM_SCHED -- requirements
Module: fir4_tdm_sched

---
 rtl/fir4_tdm_sched.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/fir4_tdm_sched.sv
// fir4_tdm_sched: time-division-multiplexed 4-tap moving sum shared by NCH channels.
// A round-robin arbiter picks one eligible channel per cycle. That channel's
// 4-deep history shifts in the new sample, and the tap sum comes out two edges
// after acceptance.
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous active-low reset
//   in_valid   : per-channel sample offer
//   in_data    : channel i sample on [i*w +: w], unsigned
//   in_ready   : one-hot grant (combinational; zero while stalled, flushing or idle)
//   ch_en      : per-channel grant eligibility
//   flush      : single-cycle request to clear every channel history
//   flush_busy : high while the flush sweep runs (NCH cycles)
//   out_valid  : out_data/out_ch hold a result
//   out_ready  : sink accepts the result when out_valid is also high
//   out_data   : w+2 bit unsigned sum of the channel's four newest samples
//   out_ch     : channel index of out_data
module fir4_tdm_sched #(
  parameter int unsigned w   = 16,
  parameter int unsigned NCH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NCH-1:0]          in_valid,
  input  logic [NCH*w-1:0]        in_data,
  output logic [NCH-1:0]          in_ready,
  input  logic [NCH-1:0]          ch_en,
  input  logic                    flush,
  output logic                    flush_busy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [w+1:0]            out_data,
  output logic [$clog2(NCH)-1:0]  out_ch
);

  localparam int unsigned CW = $clog2(NCH);
  localparam int unsigned OW = w + 2;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   fcnt_q, fcnt_d;

  logic [w-1:0]    hist_q [NCH][4];
  logic [CW-1:0]   rr_q;
  logic            s1_valid_q;
  logic [OW-1:0]   s1_sum_q;
  logic [CW-1:0]   s1_ch_q;
  logic            out_valid_q;
  logic [OW-1:0]   out_data_q;
  logic [CW-1:0]   out_ch_q;

  logic [w-1:0]    samp [NCH];
  logic [NCH-1:0]  elig;
  logic            grant_found;
  logic [CW-1:0]   grant_idx;
  logic [31:0]     grant_pos;
  logic            can_grant;
  logic            stall;
  logic            accept;
  logic [w-1:0]    sel_sample;
  logic [OW-1:0]   new_sum;

  // Unpack the sample bus into one lane per channel.
  for (genvar g = 0; g < NCH; g++) begin : g_lane
    assign samp[g] = in_data[g*w +: w];
  end

  assign elig      = in_valid & ch_en;
  assign stall     = out_valid_q & ~out_ready;
  // Flush wins over a same-cycle handshake, so the grant is withheld when flush is seen.
  assign can_grant = reset & (state_q == RUN) & ~stall & ~flush;

  // Round-robin search: first eligible channel at or after rr_q, wrapping at NCH.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_pos   = '0;
    for (int unsigned off = 0; off < NCH; off++) begin
      grant_pos = 32'(rr_q) + off;
      if (grant_pos >= NCH) grant_pos = grant_pos - NCH;
      if (!grant_found && elig[CW'(grant_pos)]) begin
        grant_found = 1'b1;
        grant_idx   = CW'(grant_pos);
      end
    end
  end

  assign in_ready   = (grant_found && can_grant) ? (NCH'(1'b1) << grant_idx) : '0;
  assign accept     = |(in_ready & in_valid);
  assign sel_sample = samp[grant_idx];

  // Sum of the post-shift window: the new sample plus the three newest stored taps.
  // It is captured at acceptance so a later flush sweep cannot disturb a pending result.
  assign new_sum = OW'(sel_sample) + OW'(hist_q[grant_idx][0])
                 + OW'(hist_q[grant_idx][1]) + OW'(hist_q[grant_idx][2]);

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // FSM next state: the flush sweep visits channel 0..NCH-1, one per cycle.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      RUN: begin
        if (flush) begin
          state_d = FLUSH;
          fcnt_d  = '0;
        end
      end
      FLUSH: begin
        if (fcnt_q == CW'(NCH - 1)) state_d = RUN;
        else                        fcnt_d  = fcnt_q + CW'(1);
      end
      default: state_d = RUN;
    endcase
  end

  assign flush_busy = (state_q == FLUSH);

  // Per-channel histories: cleared by the flush sweep, shifted on acceptance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        for (int unsigned t = 0; t < 4; t++) hist_q[c][t] <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < NCH; c++) begin
        if (state_q == FLUSH && fcnt_q == CW'(c)) begin
          for (int unsigned t = 0; t < 4; t++) hist_q[c][t] <= '0;
        end else if (accept && grant_idx == CW'(c)) begin
          hist_q[c][0] <= sel_sample;
          hist_q[c][1] <= hist_q[c][0];
          hist_q[c][2] <= hist_q[c][1];
          hist_q[c][3] <= hist_q[c][2];
        end
      end
    end
  end

  // Two-stage result pipeline and round-robin pointer; everything freezes on stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_q        <= '0;
      s1_valid_q  <= 1'b0;
      s1_sum_q    <= '0;
      s1_ch_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else if (!stall) begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_sum_q <= new_sum;
        s1_ch_q  <= grant_idx;
        rr_q     <= (grant_idx == CW'(NCH - 1)) ? '0 : grant_idx + CW'(1);
      end
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_data_q <= s1_sum_q;
        out_ch_q   <= s1_ch_q;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule
